// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by instr_fetch_unit; optional macro FETCH_MISALIGN_CHECK_EN.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction register and req/ack memory FSM.
// Define FETCH_MISALIGN_CHECK_EN to enable the misaligned-PC fault.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [63:0] pc_next,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        ir_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        fetch_busy,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [31:0]       count_q, count_d;
  logic [XLEN-1:0]   start_pc;
  fetch_state_t      start_state;

  // Destination of a fetch launch: a same-cycle pc_load redirects it.
  always_comb begin
    start_pc    = pc_load ? pc_next : pc_q;
    start_state = REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (start_pc[1:0] != 2'b00) begin
      start_state = FAULT;
    end
`endif
  end

  // Next-state logic for FSM, PC, IR and completed-fetch counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    count_d = count_q;
    unique case (state_q)
      IDLE, VALID: begin
        if (pc_load) begin
          pc_d = pc_next;
        end
        if (fetch_start) begin
          state_d = start_state;
        end else if (pc_load) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          count_d = count_q + 32'd1;
          state_d = VALID;
        end
      end
      FAULT: begin
        if (pc_load) begin
          pc_d    = pc_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    imem_req    = (state_q == REQ);
    fetch_busy  = (state_q == REQ);
    ir_valid    = (state_q == VALID);
    imem_addr   = pc_q;
    pc          = pc_q;
    pc_plus4    = pc_q + 64'd4;
    instruction = ir_q;
    fetch_count = count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_fault = (state_q == FAULT);
`else
    fetch_fault = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Honors FETCH_MISALIGN_CHECK_EN to pick the misalign expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic        pc_load;
  logic [63:0] pc_next;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        ir_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fetch_busy;
  logic [31:0] fetch_count;
  logic        fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .fetch_start(fetch_start),
    .pc_load(pc_load), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .ir_valid(ir_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .fetch_busy(fetch_busy),
    .fetch_count(fetch_count),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_start = 1'b0;
    pc_load = 1'b0; pc_next = 64'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if (pc !== 64'd0 || instruction !== 32'h13 || ir_valid !== 1'b0
        || imem_req !== 1'b0 || fetch_busy !== 1'b0
        || fetch_count !== 32'd0 || fetch_fault !== 1'b0)
      $display("FAIL reset: pc=%h ir=%h v=%b req=%b busy=%b cnt=%0d flt=%b",
               pc, instruction, ir_valid, imem_req, fetch_busy,
               fetch_count, fetch_fault);
    else n_pass++;
  endtask

  task automatic test_wait_ack();
    int reqs = 0;
    logic addr_ok = 1'b1;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req === 1'b1) reqs++;
      if (imem_addr !== 64'd0) addr_ok = 1'b0;
      imem_ack   = (i == 3);
      imem_rdata = (i == 3) ? 32'h0082_B503 : 32'hBAD0_BAD0;
      tick();
    end
    imem_ack = 1'b0;
    n_checks++;
    if (reqs !== 4) $display("FAIL wait_req_cycles: got %0d want 4", reqs);
    else n_pass++;
    n_checks++;
    if (!addr_ok) $display("FAIL wait_addr: got nonzero want 0");
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b0 || instruction !== 32'h0082_B503
        || ir_valid !== 1'b1 || fetch_count !== 32'd1)
      $display("FAIL wait_done: req=%b ir=%h v=%b cnt=%0d want 0 0082b503 1 1",
               imem_req, instruction, ir_valid, fetch_count);
    else n_pass++;
  endtask

  task automatic test_zero_wait_redirect();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b1 || instruction !== 32'h1111_2222)
      $display("FAIL zero_wait: v=%b ir=%h want 1 11112222",
               ir_valid, instruction);
    else n_pass++;
    pc_load = 1'b1; pc_next = 64'h100; fetch_start = 1'b1;
    tick();
    pc_load = 1'b0; fetch_start = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h100 || ir_valid !== 1'b0)
      $display("FAIL redirect: req=%b addr=%h v=%b want 1 100 0",
               imem_req, imem_addr, ir_valid);
    else n_pass++;
    n_checks++;
    if (pc_plus4 !== 64'h104)
      $display("FAIL pc_plus4: got %h want 104", pc_plus4);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (fetch_count !== 32'd3 || instruction !== 32'h3333_4444)
      $display("FAIL redirect_done: cnt=%0d ir=%h want 3 33334444",
               fetch_count, instruction);
    else n_pass++;
  endtask

  task automatic test_load_in_req();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    pc_load = 1'b1; pc_next = 64'h200;
    tick();
    pc_load = 1'b0;
    n_checks++;
    if (pc !== 64'h100 || imem_req !== 1'b1 || imem_addr !== 64'h100)
      $display("FAIL load_in_req: pc=%h req=%b addr=%h want 100 1 100",
               pc, imem_req, imem_addr);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'h5555_6666;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (pc !== 64'h100 || ir_valid !== 1'b1 || instruction !== 32'h5555_6666)
      $display("FAIL load_in_req_done: pc=%h v=%b ir=%h want 100 1 55556666",
               pc, ir_valid, instruction);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0 || pc !== 64'd0 || instruction !== 32'h13
        || fetch_count !== 32'd0)
      $display("FAIL reset_mid: req=%b pc=%h ir=%h cnt=%0d want 0 0 13 0",
               imem_req, pc, instruction, fetch_count);
    else n_pass++;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instruction !== 32'h13 || ir_valid !== 1'b0 || fetch_count !== 32'd0)
      $display("FAIL reset_ack_ignored: ir=%h v=%b cnt=%0d want 13 0 0",
               instruction, ir_valid, fetch_count);
    else n_pass++;
  endtask

  task automatic test_misalign();
    pc_load = 1'b1; pc_next = 64'h102; fetch_start = 1'b1;
    tick();
    pc_load = 1'b0; fetch_start = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_checks++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0)
      $display("FAIL misalign_fault: flt=%b req=%b v=%b want 1 0 0",
               fetch_fault, imem_req, ir_valid);
    else n_pass++;
    pc_load = 1'b1; pc_next = 64'h104;
    tick();
    pc_load = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b0 || pc !== 64'h104 || imem_req !== 1'b0)
      $display("FAIL fault_clear: flt=%b pc=%h req=%b want 0 104 0",
               fetch_fault, pc, imem_req);
    else n_pass++;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h104)
      $display("FAIL refetch: req=%b addr=%h want 1 104", imem_req, imem_addr);
    else n_pass++;
`else
    n_checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h102)
      $display("FAIL misalign_nochk: flt=%b req=%b addr=%h want 0 1 102",
               fetch_fault, imem_req, imem_addr);
    else n_pass++;
`endif
    imem_ack = 1'b1; imem_rdata = 32'h7777_8888;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b1 || instruction !== 32'h7777_8888
        || fetch_count !== 32'd1)
      $display("FAIL misalign_done: v=%b ir=%h cnt=%0d want 1 77778888 1",
               ir_valid, instruction, fetch_count);
    else n_pass++;
  endtask

  task automatic test_count_wrap();
    force dut.count_q = 32'hFFFF_FFFF;
    tick();
    release dut.count_q;
    tick();
    n_checks++;
    if (fetch_count !== 32'hFFFF_FFFF)
      $display("FAIL count_preset: got %h want ffffffff", fetch_count);
    else n_pass++;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (fetch_count !== 32'd0 || ir_valid !== 1'b1)
      $display("FAIL count_wrap: cnt=%h v=%b want 0 1", fetch_count, ir_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wait_ack();
    test_zero_wait_redirect();
    test_load_in_req();
    test_reset_mid();
    test_misalign();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the multi-cycle RISC-V core. Holds the 64-bit PC and requests one 32-bit instruction word per fetch from instruction memory over a req/ack handshake. Latches the word into the instruction register (IR), whose output drives the decoder and the immediate extender directly. Advances only under control of the core's main FSM.

## Interface
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- fetch_start  in  1  core FSM requests a fetch at the current PC
- pc_load  in  1  load `pc_next` into the PC (branch target or pc+4 write-back)
- pc_next  in  64  new PC value
- imem_req  out  1  instruction memory read request
- imem_addr  out  64  read address; always equals `pc`
- imem_ack  in  1  memory returns `imem_rdata` this cycle
- imem_rdata  in  32  instruction word
- instruction  out  32  IR contents; feeds decoder/extender
- ir_valid  out  1  IR holds the word fetched from the current `pc`
- pc  out  64  current PC register
- pc_plus4  out  64  `pc` + 4, combinational, modulo 2^64
- fetch_busy  out  1  high while a memory transaction is outstanding
- fetch_count  out  32  number of completed fetches; wraps 2^32-1 -> 0
- fetch_fault  out  1  misaligned-PC fault (only with macro, else tied 0)

## Operation
- FSM states: IDLE, REQ, VALID, FAULT (FAULT exists only with macro).
- IDLE: `ir_valid`=0. `fetch_start` -> REQ (-> FAULT if macro and `pc[1:0]`!=0).
- REQ: `imem_req`=1, `fetch_busy`=1. On `imem_ack`: IR<=`imem_rdata`, `fetch_count`++, -> VALID.
- VALID: `ir_valid`=1. `fetch_start` -> REQ (or FAULT), `ir_valid` drops next cycle.
- FAULT: `fetch_fault`=1, `ir_valid`=0. No memory request is issued. `pc_load` -> IDLE.
- `pc_load` is accepted in IDLE, VALID and FAULT. It is ignored in REQ, so the PC is stable for the whole transaction.
- `pc_load` in VALID also clears `ir_valid` and moves the FSM to IDLE.
- `pc_load` and `fetch_start` in the same cycle: the PC takes `pc_next`, and the fetch proceeds at the new PC.
- `fetch_start` in REQ is ignored.
- IR holds its value until the next `imem_ack`. IR is never cleared outside reset.
- `imem_rdata` is sampled only when in REQ with `imem_ack`=1. `imem_ack` outside REQ is ignored.
- Reset values: `pc`=RESET_PC, IR=32'h0000_0013 (addi x0,x0,0), `ir_valid`=0, `imem_req`=0, `fetch_busy`=0, `fetch_count`=0, `fetch_fault`=0, state IDLE.
- Reset asserted mid-transaction: abandons the request. `imem_req` is low in the cycle after the reset edge, and any ack in that cycle is ignored.

## Timing
- `fetch_start` sampled at edge N -> `imem_req` high after edge N.
- `imem_ack` may arrive in the first REQ cycle (zero-wait memory) or any later one. There is no timeout.
- Ack sampled at edge M -> `instruction` and `ir_valid`=1 valid after edge M. The minimum start-to-valid latency is 2 edges.
- `imem_req` stays high until and including the ack cycle, then drops.
- `pc_plus4` and `imem_addr` are combinational from the `pc` register. There is no input-to-output combinational path except `imem_addr` = `pc`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - FAULT state and `fetch_fault` are implemented.
  - A fetch with `pc[1:0]`!=0 raises the fault one edge after `fetch_start` and issues no memory request.
- Not defined:
  - No alignment check; `pc[1:0]` go to memory unchanged.
  - `fetch_fault` is tied 0 and FAULT is unreachable.

## Structure
- `fetch_pkg` contents:
  - state enum `fetch_state_t` (IDLE, REQ, VALID, FAULT)
  - `NOP_INSTR` = 32'h0000_0013
  - `INSTR_W` = 32, `XLEN` = 64
- Single flat module; no sub-module. IR, PC and counter are registers alongside the FSM.

## Test plan
- Reset, then `fetch_start`, ack after 3 wait cycles with rdata 32'h0082_B503 -> `imem_req` high exactly 4 cycles, `imem_addr`=0, `instruction`=32'h0082_B503, `ir_valid`=1, `fetch_count`=1.
- Zero-wait ack in the first REQ cycle -> `ir_valid` 2 edges after `fetch_start`. Then `pc_load` with 64'h100 and `fetch_start` in the same cycle -> next request has `imem_addr`=64'h100.
- `pc_load` with 64'h200 pulsed during REQ -> `pc` unchanged, request completes at the old address.
- Reset asserted while `imem_req`=1 -> `imem_req`=0, `pc`=RESET_PC, IR=32'h0000_0013, `fetch_count`=0.
- With macro, `pc_next`=64'h102, `fetch_start` -> `fetch_fault`=1, no `imem_req`. Then `pc_load` 64'h104 -> IDLE, and the next fetch succeeds. Without macro, the same stimulus requests address 64'h102.
- `fetch_count` preset by 2^32-1 completed fetches (force) plus one more -> wraps to 0.
